// File: rtl/calc_result_bcd_if.sv
// calc_result_bcd_if
//   Bundle between the calculator core and the BCD result stage.
//   Parameters:
//     IN_W    width of the calculator result word
//     DIGITS  number of packed BCD digits returned
//   Signals:
//     res      result word, sampled by the BCD stage when it captures
//     get_res  capture request (level; the BCD stage detects the rising edge)
//     busy     conversion in flight
//     done     one-cycle pulse, bcd/neg updated this cycle
//     bcd      packed BCD, digit 0 in [3:0]
//     neg      sign of the last converted result
//   Modports:
//     master  calculator side (drives res/get_res)
//     slave   BCD stage side (drives busy/done/bcd/neg)
interface calc_result_bcd_if #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) ();
  logic [IN_W-1:0]     res;
  logic                get_res;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                neg;

  modport master (
    output res,
    output get_res,
    input  busy,
    input  done,
    input  bcd,
    input  neg
  );

  modport slave (
    input  res,
    input  get_res,
    output busy,
    output done,
    output bcd,
    output neg
  );
endinterface

// File: rtl/calc_result_bcd.sv
// calc_result_bcd
//   Downstream stage of the calculator. On a rising edge of get_res it
//   captures res and converts it to packed BCD using iterative double dabble
//   (shift-add-3), one bit per clock. When the conversion finishes, bcd/neg
//   are updated and done pulses for one cycle; the result is held until the
//   next completed conversion.
//   Parameters:
//     IN_W    width of res; conversion takes IN_W shift cycles
//     DIGITS  BCD digits out; 10**DIGITS must exceed 2**IN_W
//   Ports:
//     clk     single clock, all state on posedge
//     rst     synchronous active-high reset
//     bus     calc_result_bcd_if.slave (res, get_res, busy, done, bcd, neg)
//   Build option:
//     CALC_BCD_SIGNED_EN  when defined, res is two's complement; negative
//                         values set neg and their magnitude is converted.
//                         When undefined, res is unsigned and neg stays 0.
module calc_result_bcd #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  calc_result_bcd_if.slave      bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               get_res_q_r;
  logic [IN_W-1:0]    shreg_r, shreg_s;
  logic [BCD_W-1:0]   scratch_r, scratch_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               sign_r, sign_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [BCD_W-1:0]   bcd_r, bcd_s;
  logic               neg_r, neg_s;

  logic               start_s;
  logic               cap_sign_s;
  logic [IN_W-1:0]    cap_mag_s;

  // Adds 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = s[4*d +: 4] + 4'd3;
      end else begin
        r[4*d +: 4] = s[4*d +: 4];
      end
    end
    return r;
  endfunction

  assign start_s = bus.get_res & ~get_res_q_r;

  // Value and sign to load into the shift register at capture.
  always_comb begin
    cap_sign_s = 1'b0;
    cap_mag_s  = bus.res;
`ifdef CALC_BCD_SIGNED_EN
    // The IN_W-bit negation is exact for every negative input, including
    // the most negative one (8'h80 -> 8'h80 = 128 unsigned).
    cap_sign_s = bus.res[IN_W-1];
    if (bus.res[IN_W-1]) begin
      cap_mag_s = ~bus.res + {{(IN_W-1){1'b0}}, 1'b1};
    end else begin
      cap_mag_s = bus.res;
    end
`else
    cap_sign_s = 1'b0;
    cap_mag_s  = bus.res;
`endif
  end

  // Next-state and next-output logic for the conversion FSM.
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    scratch_s = scratch_r;
    cnt_s     = cnt_r;
    sign_s    = sign_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    bcd_s     = bcd_r;
    neg_s     = neg_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s   = ST_CONV;
          shreg_s   = cap_mag_s;
          scratch_s = {BCD_W{1'b0}};
          cnt_s     = {CNT_W{1'b0}};
          sign_s    = cap_sign_s;
          busy_s    = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_CONV: begin
        // The digit range guarantees the bit shifted out of the top digit is 0.
        scratch_s = BCD_W'({add3_digits(scratch_r), shreg_r[IN_W-1]});
        shreg_s   = {shreg_r[IN_W-2:0], 1'b0};
        cnt_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_W'(IN_W - 1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CONV;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        bcd_s   = scratch_r;
        neg_s   = sign_r;
        done_s  = 1'b1;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      get_res_q_r <= 1'b0;
      shreg_r     <= {IN_W{1'b0}};
      scratch_r   <= {BCD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sign_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bcd_r       <= {BCD_W{1'b0}};
      neg_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      get_res_q_r <= bus.get_res;
      shreg_r     <= shreg_s;
      scratch_r   <= scratch_s;
      cnt_r       <= cnt_s;
      sign_r      <= sign_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      bcd_r       <= bcd_s;
      neg_r       <= neg_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.bcd  = bcd_r;
  assign bus.neg  = neg_r;

endmodule

// File: tb/tb_calc_result_bcd.sv
// tb_calc_result_bcd
//   Directed, table-driven bench for calc_result_bcd with hand-computed
//   expected values, plus hand-written sequences for busy-time edges,
//   reset during conversion and get_res high straight out of reset.
module tb_calc_result_bcd;

  localparam int IN_W   = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 12;
  localparam int NVEC   = 13;

`ifdef CALC_BCD_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  calc_result_bcd_if #(.IN_W(IN_W), .DIGITS(DIGITS)) cbi ();

  calc_result_bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cbi)
  );

  typedef struct {
    logic [7:0]       res;
    int               hold;
    logic [BCD_W-1:0] u_bcd;
    logic [BCD_W-1:0] s_bcd;
    logic             s_neg;
  } vec_t;

  vec_t             vecs [NVEC];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [BCD_W-1:0] last_bcd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise get_res for 'hold' sampled edges and watch the DUT for 'window' cycles.
  task automatic run_conv(input logic [7:0] r, input int hold, input int window,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output logic [BCD_W-1:0] bcd_d, output logic neg_d,
                          output int unstable);
    logic [BCD_W-1:0] hold_val;
    hold_val = last_bcd;
    lat = -1; busy_cnt = 0; done_cnt = 0; unstable = 0;
    bcd_d = '0; neg_d = 1'b0;
    cbi.res = r;
    cbi.get_res = 1'b1;
    for (int c = 1; c <= window; c++) begin
      step();
      if (c == 1) cbi.res = ~r;
      if (c >= hold) cbi.get_res = 1'b0;
      if (cbi.busy) busy_cnt++;
      if (cbi.done) begin
        done_cnt++;
        if (lat < 0) lat = c;
        bcd_d = cbi.bcd;
        neg_d = cbi.neg;
        hold_val = cbi.bcd;
      end else if (cbi.bcd !== hold_val) begin
        unstable++;
      end
    end
  endtask

  task automatic check_conv(input string tag, input logic [7:0] r, input int hold,
                            input logic [BCD_W-1:0] u_bcd, input logic [BCD_W-1:0] s_bcd,
                            input logic s_neg);
    int lat, bc, dc, un;
    logic [BCD_W-1:0] b;
    logic n;
    logic [BCD_W-1:0] eb;
    logic en;
    eb = SIGNED_BUILD ? s_bcd : u_bcd;
    en = SIGNED_BUILD ? s_neg : 1'b0;
    run_conv(r, hold, 32, lat, bc, dc, b, n, un);
    check({tag, "_bcd"},    32'(b),  32'(eb));
    check({tag, "_neg"},    32'(n),  32'(en));
    check({tag, "_lat"},    32'(lat), 32'(IN_W + 2));
    check({tag, "_busy"},   32'(bc), 32'(IN_W + 1));
    check({tag, "_ndone"},  32'(dc), 32'd1);
    check({tag, "_stable"}, 32'(un), 32'd0);
    last_bcd = eb;
  endtask

  initial begin
    int dones;
    logic [BCD_W-1:0] b3;

    vecs[0]  = '{8'd7,   2,  12'h007, 12'h007, 1'b0};
    vecs[1]  = '{8'd255, 1,  12'h255, 12'h001, 1'b1};
    vecs[2]  = '{8'd0,   1,  12'h000, 12'h000, 1'b0};
    vecs[3]  = '{8'd10,  1,  12'h010, 12'h010, 1'b0};
    vecs[4]  = '{8'd99,  1,  12'h099, 12'h099, 1'b0};
    vecs[5]  = '{8'h80,  1,  12'h128, 12'h128, 1'b1};
    vecs[6]  = '{8'hFD,  1,  12'h253, 12'h003, 1'b1};
    vecs[7]  = '{8'd3,   20, 12'h003, 12'h003, 1'b0};
    vecs[8]  = '{8'd100, 1,  12'h100, 12'h100, 1'b0};
    vecs[9]  = '{8'd200, 3,  12'h200, 12'h056, 1'b1};
    vecs[10] = '{8'd127, 1,  12'h127, 12'h127, 1'b0};
    vecs[11] = '{8'd1,   1,  12'h001, 12'h001, 1'b0};
    vecs[12] = '{8'd58,  1,  12'h058, 12'h058, 1'b0};

    rst = 1'b1;
    cbi.res = 8'd0;
    cbi.get_res = 1'b0;
    step();
    step();
    check("rst_busy", 32'(cbi.busy), 32'd0);
    check("rst_done", 32'(cbi.done), 32'd0);
    check("rst_bcd",  32'(cbi.bcd),  32'd0);
    check("rst_neg",  32'(cbi.neg),  32'd0);
    rst = 1'b0;
    last_bcd = 12'h000;
    step();

    for (int i = 0; i < NVEC; i++) begin
      check_conv($sformatf("v%0d", i), vecs[i].res, vecs[i].hold,
                 vecs[i].u_bcd, vecs[i].s_bcd, vecs[i].s_neg);
    end

    // Second rising edge three cycles into a conversion must be ignored.
    dones = 0;
    b3 = '0;
    cbi.res = 8'd10;
    cbi.get_res = 1'b1;
    step();
    cbi.get_res = 1'b0;
    step();
    step();
    cbi.res = 8'd99;
    cbi.get_res = 1'b1;
    step();
    cbi.get_res = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (cbi.done) begin
        dones++;
        b3 = cbi.bcd;
      end
      step();
    end
    check("busy_edge_ndone", 32'(dones), 32'd1);
    check("busy_edge_bcd",   32'(b3),    32'h010);
    last_bcd = 12'h010;

    // Reset on the fourth conversion cycle aborts it.
    cbi.res = 8'd200;
    cbi.get_res = 1'b1;
    step();
    cbi.get_res = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("abort_busy", 32'(cbi.busy), 32'd0);
    check("abort_done", 32'(cbi.done), 32'd0);
    check("abort_bcd",  32'(cbi.bcd),  32'd0);
    check("abort_neg",  32'(cbi.neg),  32'd0);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (cbi.done) dones++;
    end
    check("abort_ndone", 32'(dones), 32'd0);
    last_bcd = 12'h000;
    check_conv("after_abort", 8'd42, 1, 12'h042, 12'h042, 1'b0);

    // get_res already high while reset is released counts as an edge.
    rst = 1'b1;
    cbi.get_res = 1'b1;
    cbi.res = 8'd5;
    step();
    check("rst_hi_busy", 32'(cbi.busy), 32'd0);
    check("rst_hi_bcd",  32'(cbi.bcd),  32'd0);
    rst = 1'b0;
    last_bcd = 12'h000;
    check_conv("first_after_rst", 8'd5, 1, 12'h005, 12'h005, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
